// File: rtl/stream_block_reader.sv
// Captures a block of stream words into a local buffer, throttling ready with an LFSR.
// Ends a block on the last word or on an inter-word timeout; the buffer is read back by address.
//
// state | meaning
// IDLE  | waiting for start_i, ready low
// RUN   | capturing words until length reached or timeout
module stream_block_reader #(
  parameter int          WIDTH          = 32,
  parameter int          MAX_BLOCK_SIZE = 1024,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         LW             = $clog2(MAX_BLOCK_SIZE + 1),
  localparam int         AW             = $clog2(MAX_BLOCK_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LW-1:0]    length_i,
  input  logic [7:0]       rate_i,
  input  logic [31:0]      timeout_i,
  input  logic [WIDTH-1:0] stream_s_data_i,
  input  logic             stream_s_valid_i,
  output logic             stream_s_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_timeout_o,
  output logic [LW-1:0]    count_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] len_q, len_d;
  logic [31:0]   idle_q, idle_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic          accept;
  logic          last_word;
  logic          timeout_hit;
  logic          rate_hit;
  logic [LW-1:0] len_clamped;

  logic [WIDTH-1:0] mem [MAX_BLOCK_SIZE];
  logic [WIDTH-1:0] rd_data_q;

  assign accept      = (state_q == RUN) && ready_q && stream_s_valid_i;
  assign last_word   = accept && ((count_q + LW'(1)) == len_q);
  assign timeout_hit = (state_q == RUN) && !accept && (timeout_i != 32'd0) && (idle_q == timeout_i);
  assign rate_hit    = (lfsr_q[7:0] <= rate_i);
  assign len_clamped = (length_i > LW'(MAX_BLOCK_SIZE)) ? LW'(MAX_BLOCK_SIZE) : length_i;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    count_d = count_q;
    len_d   = len_q;
    idle_d  = (idle_q == 32'hFFFF_FFFF) ? idle_q : idle_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          count_d = '0;
          err_d   = 1'b0;
          if (length_i == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = len_clamped;
            state_d = RUN;
            ready_d = rate_hit;
            idle_d  = 32'd0;
          end
        end
      end
      RUN: begin
        if (accept) begin
          count_d = count_q + LW'(1);
          idle_d  = 32'd0;
          if (last_word) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ready_d = rate_hit;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ready_d = rate_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
      idle_q  <= 32'd0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
      len_q   <= len_d;
      idle_q  <= idle_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Buffer has no reset so it maps onto plain RAM; contents survive start and reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[count_q[AW-1:0]] <= stream_s_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign stream_s_ready_o = ready_q;
  assign busy_o           = (state_q == RUN);
  assign done_o           = done_q;
  assign err_timeout_o    = err_q;
  assign count_o          = count_q;
  assign rd_data_o        = rd_data_q;

endmodule

// File: tb/tb_stream_block_reader.sv
// Directed bench for stream_block_reader: accepted words go to a scoreboard queue
// and are compared against the buffer readback after each block.
module tb_stream_block_reader;
  localparam int WIDTH = 32;
  localparam int MAXB  = 128;
  localparam int LW    = $clog2(MAXB + 1);
  localparam int AW    = $clog2(MAXB);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LW-1:0]    length = '0;
  logic [7:0]       rate = 8'd0;
  logic [31:0]      timeout = 32'd0;
  logic [WIDTH-1:0] sdata = '0;
  logic             svalid = 1'b0;
  logic             sready;
  logic             busy;
  logic             done;
  logic             err;
  logic [LW-1:0]    count;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data;

  always #5 clk = ~clk;

  stream_block_reader #(.WIDTH(WIDTH), .MAX_BLOCK_SIZE(MAXB), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .length_i(length), .rate_i(rate),
    .timeout_i(timeout), .stream_s_data_i(sdata), .stream_s_valid_i(svalid),
    .stream_s_ready_o(sready), .busy_o(busy), .done_o(done), .err_timeout_o(err),
    .count_o(count), .rd_addr_i(rd_addr), .rd_data_o(rd_data)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_k = 0;
  int done_cnt = 0;
  int run_cyc = 0;
  int ready_cyc = 0;
  int last_acc_cyc = 0;
  int done_cyc = 0;
  bit busy_seen = 1'b0;
  bit ready_seen = 1'b0;
  int vmode = 0;
  int vlimit = 0;
  logic [31:0] base = 32'd0;
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Handshake and status monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (svalid && sready) begin
        exp_q.push_back(sdata);
        acc_k++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) begin
        busy_seen = 1'b1;
        run_cyc++;
      end
      if (sready) begin
        ready_seen = 1'b1;
        ready_cyc++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sdata = base + 32'(acc_k);
    case (vmode)
      0: svalid = 1'b0;
      1: svalid = 1'b1;
      2: svalid = 1'($urandom_range(0, 1));
      default: svalid = (acc_k < vlimit);
    endcase
  endtask

  task automatic new_block(input logic [31:0] b);
    base = b;
    acc_k = 0;
    exp_q.delete();
    done_cnt = 0;
    run_cyc = 0;
    ready_cyc = 0;
    busy_seen = 1'b0;
    ready_seen = 1'b0;
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    length = LW'(len);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int b = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && b < budget) begin
      step();
      b++;
    end
    check("wait_done", 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic readback(input int n);
    vmode = 0;
    for (int i = 0; i < n; i++) begin
      rd_addr = AW'(i);
      step();
      if (exp_q.size() == 0) check("rd_queue_empty", 64'(i), 64'(n));
      else check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
    end
    check("rd_queue_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_ready", 64'(sready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Full-rate block of 8
    rate = 8'd255;
    timeout = 32'd0;
    vmode = 1;
    new_block(32'hA000_0000);
    do_start(8);
    for (int i = 1; i <= 8; i++) begin
      check("full_ready", 64'(sready), 64'd1);
      check("full_done_early", 64'(done), 64'd0);
      step();
    end
    check("full_ready_end", 64'(sready), 64'd0);
    check("full_done", 64'(done), 64'd1);
    check("full_busy_end", 64'(busy), 64'd0);
    check("full_count", 64'(count), 64'd8);
    readback(8);

    // Timeout after 3 words of 10
    rate = 8'd255;
    timeout = 32'd20;
    vmode = 3;
    vlimit = 3;
    new_block(32'hB000_0000);
    do_start(10);
    wait_done(200);
    check("to_err", 64'(err), 64'd1);
    check("to_count", 64'(count), 64'd3);
    check("to_latency", 64'(done_cyc - last_acc_cyc), 64'd22);
    ready_seen = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("to_ready_after", 64'(ready_seen), 64'd0);
    check("to_done_once", 64'(done_cnt), 64'd1);
    readback(3);
    check("to_err_sticky", 64'(err), 64'd1);

    // Zero-length start
    vmode = 1;
    new_block(32'hC000_0000);
    do_start(0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_err_clr", 64'(err), 64'd0);
    check("zero_count", 64'(count), 64'd0);
    step();
    check("zero_done_pulse", 64'(done), 64'd0);
    check("zero_busy_seen", 64'(busy_seen), 64'd0);
    check("zero_ready_seen", 64'(ready_seen), 64'd0);
    check("zero_done_once", 64'(done_cnt), 64'd1);

    // Half-rate throttle with random valid, length 100
    rate = 8'd127;
    timeout = 32'd0;
    vmode = 2;
    new_block(32'hD000_0000);
    do_start(100);
    wait_done(5000);
    check("rnd_count", 64'(count), 64'd100);
    check("rnd_err", 64'(err), 64'd0);
    check("rnd_done_once", 64'(done_cnt), 64'd1);
    check("rnd_duty", 64'((ready_cyc * 100 >= run_cyc * 40) && (ready_cyc * 100 <= run_cyc * 60)), 64'd1);
    readback(100);

    // Oversized length clamps; start during RUN is ignored
    rate = 8'd255;
    vmode = 1;
    new_block(32'hE000_0000);
    do_start(200);
    for (int i = 0; i < 5; i++) step();
    start = 1'b1;
    length = LW'(3);
    step();
    start = 1'b0;
    check("clamp_busy", 64'(busy), 64'd1);
    wait_done(400);
    check("clamp_count", 64'(count), 64'd128);
    check("clamp_done_once", 64'(done_cnt), 64'd1);
    check("clamp_err", 64'(err), 64'd0);
    readback(128);

    // Reset mid-block, then a fresh block of 4
    vmode = 1;
    new_block(32'hF000_0000);
    do_start(10);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(sready), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_rd_data", 64'(rd_data), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("arst_no_done", 64'(done_cnt), 64'd0);
    check("arst_idle", 64'(busy), 64'd0);
    new_block(32'h1234_0000);
    do_start(4);
    wait_done(50);
    check("fresh_count", 64'(count), 64'd4);
    check("fresh_done_once", 64'(done_cnt), 64'd1);
    readback(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stream_block_reader.md
STREAM_BLOCK_READER -- requirements
Module: stream_block_reader

Interface
REQ-001 Parameter WIDTH, default 32, stream data width in bits (>=1).
REQ-002 Parameter MAX_BLOCK_SIZE, default 1024, capture buffer depth in words (>=2).
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero reset value of the 16-bit throttle LFSR.
REQ-004 Derived: LW = $clog2(MAX_BLOCK_SIZE+1), AW = $clog2(MAX_BLOCK_SIZE).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start_i  in  1  one-cycle request to capture a block.
REQ-008 length_i  in  LW  words in block, sampled on accepted start.
REQ-009 rate_i  in  8  ready probability, (rate_i+1)/256 per cycle.
REQ-010 timeout_i  in  32  max cycles between accepted words, 0 = disabled.
REQ-011 stream_s_data_i  in  WIDTH  stream data.
REQ-012 stream_s_valid_i  in  1  stream valid.
REQ-013 stream_s_ready_o  out  1  stream ready, registered.
REQ-014 busy_o  out  1  high while block capture is in progress.
REQ-015 done_o  out  1  one-cycle pulse at block end (normal or timeout).
REQ-016 err_timeout_o  out  1  sticky timeout flag.
REQ-017 count_o  out  LW  words accepted in current/last block.
REQ-018 rd_addr_i  in  AW  capture buffer read address.
REQ-019 rd_data_o  out  WIDTH  capture buffer read data, registered.

Function
REQ-020 States IDLE and RUN; busy_o = (state == RUN).
REQ-021 Handshake: word accepted in a cycle where stream_s_valid_i and stream_s_ready_o are both high.
REQ-022 IDLE + start_i, length_i > 0: latch length (clamped to MAX_BLOCK_SIZE), clear count_o and err_timeout_o, go RUN.
REQ-023 IDLE + start_i, length_i == 0: clear count_o and err_timeout_o, pulse done_o next cycle, stay IDLE.
REQ-024 start_i while RUN is ignored.
REQ-025 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle regardless of state.
REQ-026 In RUN, next stream_s_ready_o = (lfsr[7:0] <= rate_i), except forced 0 when the current cycle completes the block or fires timeout; rate_i = 255 yields ready high every RUN cycle.
REQ-027 In IDLE stream_s_ready_o is 0; ready may deassert without a handshake.
REQ-028 Each accepted word is written to buffer[count_o] and count_o increments the same edge.
REQ-029 Accept of word number length-1 (0-based): next edge state = IDLE, done_o = 1, stream_s_ready_o = 0.
REQ-030 Idle counter clears on RUN entry and each accept, else increments, saturating at 2^32-1.
REQ-031 timeout_i != 0 and idle counter == timeout_i with no accept this cycle: next edge err_timeout_o = 1, done_o = 1, state = IDLE, count_o holds partial count.
REQ-032 Accept and timeout in the same cycle: accept wins, idle counter clears, no error.
REQ-033 err_timeout_o stays high until next accepted start_i.
REQ-034 rd_data_o = buffer[rd_addr_i] one cycle after address; read/write same address same cycle returns old data.
REQ-035 Buffer contents not cleared by start or reset; rd_addr_i >= count_o returns undefined data.

Reset
REQ-036 rst_n low immediately forces state IDLE, stream_s_ready_o 0, done_o 0, err_timeout_o 0, count_o 0, idle counter 0, LFSR = LFSR_SEED, rd_data_o 0.
REQ-037 Reset mid-block aborts capture with no done_o pulse; first start after release behaves per REQ-022.

Verification
REQ-038 rate_i=255, valid always high, start length 8 -> ready high 8 consecutive cycles from cycle after start, done_o at cycle 9, count_o=8, buffer 0..7 match data.
REQ-039 rate_i=127, random valid, length 100 -> count_o=100, data in order, ready duty 40-60%, no err.
REQ-040 length 0 -> done_o one cycle after start, busy_o never high, ready never high.
REQ-041 timeout_i=20, valid low after 3 words of length 10 -> err_timeout_o=1, done_o once, count_o=3, ready low thereafter.
REQ-042 start_i pulsed during RUN and length_i > MAX_BLOCK_SIZE -> second start ignored; block ends at MAX_BLOCK_SIZE words.
REQ-043 rst_n asserted mid-block -> all outputs reset asynchronously, no done_o; fresh block of 4 then completes correctly.
